demux_frame_7bits: RTL and testbench

Receive side of the time-multiplexed 7-bit segment bus: a sender alternates two 7-bit words on one bus, tagged by `sel` and qualified by `valid`. This block does the following:
- demultiplexes the words into two shadow registers;
- checks the sel=0 then sel=1 ordering;
- commits both words atomically as one frame;
- scans the committed pair onto a shared segment output with per-digit enables.

It sits between the multiplexed bus and the two-digit seven-segment display.

---
 rtl/demux_frame_7bits_pkg.sv | 13 +
 rtl/demux_frame_7bits_mux.sv | 13 +
 rtl/demux_frame_7bits.sv | 106 ++++++++++
 tb/tb_demux_frame_7bits.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/demux_frame_7bits_pkg.sv
// Shared encodings for the multiplexed segment-bus receiver:
// frame FSM states and one-hot digit enables.
package demux_frame_7bits_pkg;

    typedef enum logic {
        WAIT0 = 1'b0,
        WAIT1 = 1'b1
    } frame_state_t;

    localparam logic [1:0] AN_D0 = 2'b01;
    localparam logic [1:0] AN_D1 = 2'b10;

endpackage

// File: rtl/demux_frame_7bits_mux.sv
// Two-way word selector used to route the scanned digit's word onto seg.
module Mux2x1_7bits #(
    parameter int P_DATA = 7
) (
    input  logic              sel,
    input  logic [P_DATA-1:0] ent0,
    input  logic [P_DATA-1:0] ent1,
    output logic [P_DATA-1:0] s
);

    assign s = sel ? ent1 : ent0;

endmodule

// File: rtl/demux_frame_7bits.sv
// Receiver for the time-multiplexed two-digit segment bus: demuxes tagged
// words, commits them as an atomic frame, and scans the pair onto the display.
module demux_frame_7bits
    import demux_frame_7bits_pkg::*;
#(
    parameter int P_DATA = 7,
    parameter int P_DIV  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              sel,
    input  logic [P_DATA-1:0] ent,
    output logic [P_DATA-1:0] out0,
    output logic [P_DATA-1:0] out1,
    output logic              done,
    output logic              err,
    output logic [P_DATA-1:0] seg,
    output logic [1:0]        an
);

    localparam int CW = $clog2(P_DIV);

    frame_state_t      state, state_nx;
    logic [P_DATA-1:0] shadow0;
    logic              ld_shadow, commit, err_nx;
    logic [CW-1:0]     cnt;
    logic              digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT0;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (valid) begin
            case (state)
                WAIT0:   if (!sel) state_nx = WAIT1;
                WAIT1:   if (sel)  state_nx = WAIT0;
                default: state_nx = WAIT0;
            endcase
        end
    end

    // A sel=0 word in WAIT1 restarts the frame rather than being dropped.
    always_comb begin
        ld_shadow = 1'b0;
        commit    = 1'b0;
        err_nx    = 1'b0;
        if (valid) begin
            case (state)
                WAIT0: begin
                    ld_shadow = !sel;
                    err_nx    = sel;
                end
                WAIT1: begin
                    commit    = sel;
                    ld_shadow = !sel;
                    err_nx    = !sel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow0 <= '0;
            out0    <= '0;
            out1    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= commit;
            err  <= err_nx;
            if (ld_shadow) shadow0 <= ent;
            if (commit) begin
                out0 <= shadow0;
                out1 <= ent;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            digit <= 1'b0;
        end else if (cnt == CW'(P_DIV - 1)) begin
            cnt   <= '0;
            digit <= ~digit;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign an = digit ? AN_D1 : AN_D0;

    Mux2x1_7bits #(.P_DATA(P_DATA)) u_seg_mux (
        .sel  (digit),
        .ent0 (out0),
        .ent1 (out1),
        .s    (seg)
    );

endmodule

// File: tb/tb_demux_frame_7bits.sv
// Directed bench for demux_frame_7bits: frame ordering, resync, gaps,
// full-rate frames, scan timing and asynchronous reset.
module tb_demux_frame_7bits;

    localparam int P_DATA = 7;
    localparam int P_DIV  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid = 1'b0;
    logic              sel = 1'b0;
    logic [P_DATA-1:0] ent = '0;
    logic [P_DATA-1:0] out0, out1, seg;
    logic              done, err;
    logic [1:0]        an;

    int n_chk = 0;
    int n_err = 0;

    logic [P_DATA-1:0] exp0 = '0;
    logic [P_DATA-1:0] exp1 = '0;
    int                mcnt;
    logic              mdig;

    demux_frame_7bits #(.P_DATA(P_DATA), .P_DIV(P_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .sel   (sel),
        .ent   (ent),
        .out0  (out0),
        .out1  (out1),
        .done  (done),
        .err   (err),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    // Expected scan position, from the dwell rule
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= 0;
            mdig <= 1'b0;
        end else if (mcnt == P_DIV - 1) begin
            mcnt <= 0;
            mdig <= ~mdig;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [P_DATA-1:0] e);
        valid = v;
        sel   = s;
        ent   = e;
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic d, input logic er);
        chk({tag, ".out0"}, 32'(out0), 32'(exp0));
        chk({tag, ".out1"}, 32'(out1), 32'(exp1));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".err"},  32'(err),  32'(er));
        chk({tag, ".an"},   32'(an),   mdig ? 32'h2 : 32'h1);
        chk({tag, ".seg"},  32'(seg),  mdig ? 32'(exp1) : 32'(exp0));
    endtask

    logic [P_DATA-1:0] fa [4];
    logic [P_DATA-1:0] fb [4];
    int ndone;

    initial begin
        fa[0] = 7'h11; fb[0] = 7'h22;
        fa[1] = 7'h33; fb[1] = 7'h44;
        fa[2] = 7'h55; fb[2] = 7'h66;
        fa[3] = 7'h77; fb[3] = 7'h08;

        // reset state
        repeat (3) @(negedge clk);
        chk_outs("reset", 1'b0, 1'b0);
        chk("reset.an01", 32'(an), 32'h1);
        rst = 1'b0;
        repeat (P_DIV - 1) step(1'b0, 1'b0, '0);
        chk("scan.before_toggle", 32'(an), 32'h1);
        step(1'b0, 1'b0, '0);
        chk("scan.first_toggle", 32'(an), 32'h2);

        // good frame
        step(1'b1, 1'b0, 7'h3F);
        chk_outs("good.w0", 1'b0, 1'b0);
        step(1'b1, 1'b1, 7'h06);
        exp0 = 7'h3F; exp1 = 7'h06;
        chk_outs("good.commit", 1'b1, 1'b0);
        step(1'b0, 1'b0, '0);
        chk_outs("good.after", 1'b0, 1'b0);

        // sel1 first in WAIT0
        step(1'b1, 1'b1, 7'h5B);
        chk_outs("ooo.err", 1'b0, 1'b1);
        step(1'b1, 1'b0, 7'h4F);
        chk_outs("ooo.w0", 1'b0, 1'b0);
        step(1'b1, 1'b1, 7'h66);
        exp0 = 7'h4F; exp1 = 7'h66;
        chk_outs("ooo.commit", 1'b1, 1'b0);

        // resync on repeated sel0
        step(1'b1, 1'b0, 7'h6D);
        chk_outs("resync.w0", 1'b0, 1'b0);
        step(1'b1, 1'b0, 7'h7D);
        chk_outs("resync.err", 1'b0, 1'b1);
        step(1'b1, 1'b1, 7'h07);
        exp0 = 7'h7D; exp1 = 7'h07;
        chk_outs("resync.commit", 1'b1, 1'b0);

        // idle gaps between words
        step(1'b1, 1'b0, 7'h3F);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 7'h7F);
            chk_outs("gap.idle", 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 7'h06);
        exp0 = 7'h3F; exp1 = 7'h06;
        chk_outs("gap.commit", 1'b1, 1'b0);

        // four frames at full rate
        ndone = 0;
        for (int f = 0; f < 4; f++) begin
            step(1'b1, 1'b0, fa[f]);
            chk_outs("full.w0", 1'b0, 1'b0);
            step(1'b1, 1'b1, fb[f]);
            exp0 = fa[f]; exp1 = fb[f];
            chk_outs("full.commit", 1'b1, 1'b0);
            if (done) ndone++;
        end
        chk("full.ndone", 32'(ndone), 32'd4);

        // asynchronous reset after the first word of a frame
        step(1'b1, 1'b0, 7'h55);
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        exp0 = '0; exp1 = '0;
        chk_outs("arst.clear", 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b1, 7'h12);
        chk_outs("arst.sel1_err", 1'b0, 1'b1);
        step(1'b0, 1'b0, '0);
        chk_outs("arst.after", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
